btn_debounce: RTL
=================

BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 The module SHALL have parameter DEBOUNCE_CYCLES, default 16, the number of consecutive cycles a changed input must hold before it is accepted; legal values are 2 or more.
REQ-002 The module SHALL have parameter CNT_WIDTH, default 16, the width of each debounce counter; legal values satisfy 2^CNT_WIDTH > DEBOUNCE_CYCLES.
REQ-003 Port clk: input, 1 bit, the single clock; all logic is clocked on its rising edge.
REQ-004 Port rst: input, 1 bit; reset is synchronous and active-high.
REQ-005 Port btn1_n: input, 1 bit, raw asynchronous button 1; active-low (0 = pressed).
REQ-006 Port btn2_n: input, 1 bit, raw asynchronous button 2; active-low (0 = pressed).
REQ-007 Port btn_level: output, 2 bits, debounced state; active-high; bit 0 is button 1, bit 1 is button 2.
REQ-008 Port btn_press: output, 2 bits, one-cycle pulse per bit on a debounced press.
REQ-009 Port btn_release: output, 2 bits, one-cycle pulse per bit on a debounced release.

Function
REQ-010 Each channel SHALL pass its raw input through a 2-flop synchronizer (sync1, then sync2) and invert it, giving sample s (1 = pressed).
REQ-011 Each channel SHALL be fully independent, with its own synchronizer, counter and level register; both channels may change in the same cycle.
REQ-012 On each clock edge where s equals btn_level[i], cnt[i] SHALL be cleared to 0.
REQ-013 On each clock edge where s differs from btn_level[i] and cnt[i] < DEBOUNCE_CYCLES-1, cnt[i] SHALL increment by 1.
REQ-014 On an edge where s differs from btn_level[i] and cnt[i] == DEBOUNCE_CYCLES-1, btn_level[i] SHALL take the value of s and cnt[i] SHALL clear to 0.
REQ-015 An accepted change therefore requires DEBOUNCE_CYCLES consecutive mismatching edges; any matching edge in between restarts the count from 0.
REQ-016 Latency: a clean step first captured by sync1 at edge E SHALL update btn_level at edge E+DEBOUNCE_CYCLES+1.
REQ-017 A glitch lasting fewer than DEBOUNCE_CYCLES cycles at s SHALL NOT change btn_level and SHALL NOT produce a pulse.
REQ-018 btn_press[i] SHALL be registered and be high for exactly the one cycle following the edge on which btn_level[i] goes 0 to 1; it is low at all other times.
REQ-019 btn_release[i] SHALL be registered and be high for exactly the one cycle following the edge on which btn_level[i] goes 1 to 0; it is low at all other times.
REQ-020 A held button SHALL produce exactly one btn_press pulse, with no auto-repeat.
REQ-021 btn_press[i] and btn_release[i] SHALL never be high in the same cycle.
REQ-022 The counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap around.
REQ-023 Outputs SHALL be driven only from registers; there is no combinational path from input to output.

Reset
REQ-024 While rst is high at a clock edge, the module SHALL set sync1 and sync2 to 1 (released), cnt to 0, btn_level to 2'b00, btn_press to 2'b00 and btn_release to 2'b00.
REQ-025 Reset asserted mid-count SHALL discard the partial count, and no pulse SHALL follow.
REQ-026 If a button is held through reset, it SHALL be re-debounced after reset release: btn_press fires DEBOUNCE_CYCLES+2 edges after the first edge with rst low.
REQ-027 A reset arriving in the same cycle as an acceptance SHALL win; no pulse is produced.

Verification (DEBOUNCE_CYCLES = 4)
REQ-028 Scenario 1: reset, then hold btn1_n=0 from edge E. Required response: btn_level[0]=1 at edge E+5; btn_press=2'b01 for one cycle; btn_level[1] stays 0.
REQ-029 Scenario 2: btn1_n low for 3 cycles, then high. Required response: btn_level, btn_press and btn_release remain 0 throughout.
REQ-030 Scenario 3: bounce pattern 0,1,0,0,1,0 followed by a steady 0. Required response: exactly one btn_press, occurring 4 consecutive sample-0 edges after the last bounce.
REQ-031 Scenario 4: release a pressed btn2 (btn2_n=1 steady). Required response: btn_level[1]=0 after 5 edges; btn_release=2'b10 for one cycle; no btn_press.
REQ-032 Scenario 5: press both buttons on the same edge. Required response: btn_press=2'b11 for one cycle.
REQ-033 Scenario 6: assert rst after 2 of 4 counting edges, then deassert with the button released. Required response: no pulse and btn_level=0; then press held through reset, and btn_press fires 6 edges after rst falls.

Source files
------------

// File: rtl/btn_debounce.sv
// ============================================================================
// btn_debounce
//
// Two-channel push-button debouncer.
//
// Each channel works on its own and follows the same steps:
//   1. The raw active-low button input goes through a two-flop synchronizer.
//   2. The synchronized value is inverted to give a sample s (1 = pressed).
//   3. A counter counts the consecutive clock edges on which s disagrees with
//      the debounced level.
//   4. The debounced level takes the new value only after DEBOUNCE_CYCLES such
//      edges in a row. One agreeing edge restarts the count from zero.
//
// Press and release pulses come from an edge detector on the registered level.
// Each pulse is high for exactly one cycle.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive disagreeing edges needed to accept a change.
//                    Must be 2 or more.
//   CNT_WIDTH        width of each debounce counter.
//                    Must satisfy 2**CNT_WIDTH > DEBOUNCE_CYCLES.
//
// Ports
//   clk          rising-edge clock for all logic
//   rst          synchronous, active-high reset
//   btn1_n       raw asynchronous button 1, active-low (0 = pressed)
//   btn2_n       raw asynchronous button 2, active-low (0 = pressed)
//   btn_level    debounced state, active-high
//                (bit 0 = button 1, bit 1 = button 2)
//   btn_press    one-cycle pulse per bit when the debounced level goes 0 -> 1
//   btn_release  one-cycle pulse per bit when the debounced level goes 1 -> 0
// ============================================================================
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_WIDTH       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn1_n,
    input  logic       btn2_n,
    output logic [1:0] btn_level,
    output logic [1:0] btn_press,
    output logic [1:0] btn_release
);

    // Counter value on the last disagreeing edge before a change is accepted.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic [1:0]           raw_n;    // {btn2_n, btn1_n}
    logic [1:0]           sync1;    // first synchronizer stage (active-low)
    logic [1:0]           sync2;    // second synchronizer stage (active-low)
    logic [1:0]           sample;   // synchronized and inverted, 1 = pressed
    logic [1:0]           level_q;  // btn_level delayed by one cycle, for edges
    logic [CNT_WIDTH-1:0] cnt [2];  // one debounce counter per channel

    assign raw_n  = {btn2_n, btn1_n};
    assign sample = ~sync2;

    // NOTE: every register in this block uses non-blocking assignments.
    // All right-hand sides then see the values from before the clock edge.
    // Because of this, the pulse logic below reads the old btn_level even
    // though btn_level is updated later in the same block.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the counters are cleared explicitly along with all other
            // state. This throws away a partial count, and nothing stays
            // unknown after reset.
            sync1       <= 2'b11;
            sync2       <= 2'b11;
            cnt[0]      <= '0;
            cnt[1]      <= '0;
            btn_level   <= 2'b00;
            level_q     <= 2'b00;
            btn_press   <= 2'b00;
            btn_release <= 2'b00;
        end else begin
            sync1 <= raw_n;
            sync2 <= sync1;

            // The pulses use the level from one cycle back. So a press shows up
            // one cycle after btn_level rises. A reset on the accepting edge
            // clears level_q and btn_level together, so no pulse follows it.
            level_q     <= btn_level;
            btn_press   <= btn_level & ~level_q;
            btn_release <= ~btn_level & level_q;

            for (int i = 0; i < 2; i++) begin
                if (sample[i] == btn_level[i]) begin
                    // The sample agrees with the level: restart the count.
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    // This is the DEBOUNCE_CYCLES-th disagreeing edge in a row:
                    // accept the change and clear the counter.
                    btn_level[i] <= sample[i];
                    cnt[i]       <= '0;
                end else begin
                    // The counter stops at CNT_LAST and never wraps.
                    cnt[i] <= cnt[i] + CNT_ONE;
                end
            end
        end
    end

endmodule
